alu_uart_frame_engine: RTL and testbench

Parametrised successor to the single-byte UART/ALU interface. It collects a framed command from the UART RX FIFO: one opcode byte, then operand A and operand B as multi-byte words, least significant byte first. It executes the command in an internal ALU that also produces status flags, then returns the result bytes and a flags byte through the UART TX FIFO. It sits between the UART core FIFOs and the rest of the top level, and adds inter-byte timeout recovery.

---
 rtl/alu_uart_frame_engine.sv | 207 ++++++++++++++++++++
 tb/tb_alu_uart_frame_engine.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_uart_frame_engine.sv
// Framed UART command engine: opcode, A, B in (LSB first), result and flags out.
// Includes an ALU with zero/carry/overflow/invalid flags and inter-byte timeout.
module alu_uart_frame_engine #(
    parameter int DBIT    = 8,
    parameter int NB_OP   = 6,
    parameter int NB_AB   = 16,
    parameter int TIMEOUT = 1000000,
    parameter int NB_TO   = 20
) (
    input  logic            clock,
    input  logic            i_reset,
    input  logic            i_rx_empty,
    input  logic [DBIT-1:0] i_r_data,
    output logic            o_rd_uart,
    input  logic            i_tx_full,
    output logic [DBIT-1:0] o_w_data,
    output logic            o_wr_uart,
    output logic            o_busy,
    output logic            o_timeout
);

    localparam int NBYTES = NB_AB / DBIT;
    localparam int NB_CNT = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [NB_CNT-1:0] LAST_BYTE = NB_CNT'(NBYTES - 1);
    localparam logic [NB_TO-1:0]  TO_LAST   = NB_TO'(TIMEOUT - 1);
    localparam logic [NB_AB-1:0]  SH_LIM    = NB_AB'(NB_AB);

    localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
    localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
    localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
    localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
    localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
    localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
    localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);
    localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);

    typedef enum logic [2:0] {
        IDLE,
        RX_A,
        RX_B,
        EXEC,
        TX_RES,
        TX_FLG
    } state_t;

    state_t            state;
    logic [NB_CNT-1:0] byte_cnt;
    logic [NB_TO-1:0]  to_cnt;
    logic [NB_OP-1:0]  opcode;
    logic [NB_AB-1:0]  a;
    logic [NB_AB-1:0]  b;
    logic [NB_AB-1:0]  result;
    logic [DBIT-1:0]   flags;

    logic              rx_state;
    logic              tx_state;
    logic              pop;
    logic              push;
    logic              last_byte;

    logic [NB_AB:0]    sum;
    logic [NB_AB-1:0]  diff;
    logic              big_shift;
    logic [NB_AB-1:0]  alu_res;
    logic              alu_c;
    logic              alu_v;
    logic              alu_inv;
    logic [DBIT-1:0]   alu_flags;

    // Handshakes are combinational so pop/push land on the same edge as capture.
    assign rx_state  = (state == IDLE) || (state == RX_A) || (state == RX_B);
    assign tx_state  = (state == TX_RES) || (state == TX_FLG);
    assign pop       = i_reset && rx_state && !i_rx_empty;
    assign push      = i_reset && tx_state && !i_tx_full;
    assign last_byte = (byte_cnt == LAST_BYTE);

    assign o_rd_uart = pop;
    assign o_wr_uart = push;
    assign o_busy    = (state != IDLE);

    always_comb begin
        o_w_data = '0;
        if (state == TX_RES) begin
            o_w_data = result[byte_cnt*DBIT +: DBIT];
        end else if (state == TX_FLG) begin
            o_w_data = flags;
        end
    end

    always_comb begin
        sum       = {1'b0, a} + {1'b0, b};
        diff      = a - b;
        big_shift = (b >= SH_LIM);
        alu_res   = '0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        alu_inv   = 1'b0;
        unique case (1'b1)
            (opcode == OP_ADD): begin
                alu_res = sum[NB_AB-1:0];
                alu_c   = sum[NB_AB];
                alu_v   = (a[NB_AB-1] == b[NB_AB-1]) &&
                          (sum[NB_AB-1] != a[NB_AB-1]);
            end
            (opcode == OP_SUB): begin
                alu_res = diff;
                alu_c   = (a < b);
                alu_v   = (a[NB_AB-1] != b[NB_AB-1]) &&
                          (diff[NB_AB-1] != a[NB_AB-1]);
            end
            (opcode == OP_AND): alu_res = a & b;
            (opcode == OP_OR):  alu_res = a | b;
            (opcode == OP_XOR): alu_res = a ^ b;
            (opcode == OP_NOR): alu_res = ~(a | b);
            // Shift amount is all of B; oversize shifts saturate explicitly.
            (opcode == OP_SRA): begin
                if (big_shift) begin
                    alu_res = {NB_AB{a[NB_AB-1]}};
                end else begin
                    alu_res = $signed(a) >>> b;
                end
            end
            (opcode == OP_SRL): begin
                if (big_shift) begin
                    alu_res = '0;
                end else begin
                    alu_res = a >> b;
                end
            end
            default: alu_inv = 1'b1;
        endcase
        alu_flags = {{(DBIT-4){1'b0}}, alu_inv, alu_v, alu_c, (alu_res == '0)};
    end

    always_ff @(posedge clock) begin
        if (!i_reset) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            to_cnt    <= '0;
            opcode    <= '0;
            a         <= '0;
            b         <= '0;
            result    <= '0;
            flags     <= '0;
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        opcode   <= i_r_data[NB_OP-1:0];
                        byte_cnt <= '0;
                        to_cnt   <= '0;
                        state    <= RX_A;
                    end
                end
                RX_A, RX_B: begin
                    if (pop) begin
                        if (state == RX_A) begin
                            a[byte_cnt*DBIT +: DBIT] <= i_r_data;
                        end else begin
                            b[byte_cnt*DBIT +: DBIT] <= i_r_data;
                        end
                        to_cnt <= '0;
                        if (last_byte) begin
                            byte_cnt <= '0;
                            state    <= (state == RX_A) ? RX_B : EXEC;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        o_timeout <= 1'b1;
                        to_cnt    <= '0;
                        byte_cnt  <= '0;
                        state     <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                EXEC: begin
                    result   <= alu_res;
                    flags    <= alu_flags;
                    byte_cnt <= '0;
                    state    <= TX_RES;
                end
                TX_RES: begin
                    if (push) begin
                        if (last_byte) begin
                            byte_cnt <= '0;
                            state    <= TX_FLG;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                TX_FLG: begin
                    if (push) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_uart_frame_engine.sv
// Directed bench for alu_uart_frame_engine (NB_AB=16, DBIT=8, TIMEOUT=16).
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_alu_uart_frame_engine;

    localparam int DBIT    = 8;
    localparam int NB_OP   = 6;
    localparam int NB_AB   = 16;
    localparam int TIMEOUT = 16;
    localparam int NB_TO   = 5;

    logic            clock;
    logic            i_reset;
    logic            i_rx_empty;
    logic [DBIT-1:0] i_r_data;
    logic            o_rd_uart;
    logic            i_tx_full;
    logic [DBIT-1:0] o_w_data;
    logic            o_wr_uart;
    logic            o_busy;
    logic            o_timeout;

    int checks = 0;
    int passed = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int to_seen = 0;
    logic [7:0] txq[$];

    alu_uart_frame_engine #(
        .DBIT(DBIT), .NB_OP(NB_OP), .NB_AB(NB_AB),
        .TIMEOUT(TIMEOUT), .NB_TO(NB_TO)
    ) dut (
        .clock(clock),
        .i_reset(i_reset),
        .i_rx_empty(i_rx_empty),
        .i_r_data(i_r_data),
        .o_rd_uart(o_rd_uart),
        .i_tx_full(i_tx_full),
        .o_w_data(o_w_data),
        .o_wr_uart(o_wr_uart),
        .o_busy(o_busy),
        .o_timeout(o_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (o_wr_uart === 1'b1) begin
            txq.push_back(o_w_data);
            wr_cnt++;
        end
        if (o_rd_uart === 1'b1) rd_cnt++;
        if (o_timeout === 1'b1) to_seen++;
    end

    task automatic send_bytes(input logic [7:0] bs[5], input int n);
        for (int i = 0; i < n; i++) begin
            i_rx_empty = 1'b0;
            i_r_data   = bs[i];
            @(posedge clock); #1;
        end
        i_rx_empty = 1'b1;
        i_r_data   = '0;
    endtask

    task automatic do_frame(input logic [7:0] op, input logic [15:0] a,
                            input logic [15:0] b, output logic [15:0] res,
                            output logic [7:0] flg);
        logic [7:0] bs[5];
        int w;
        bs[0] = op; bs[1] = a[7:0]; bs[2] = a[15:8];
        bs[3] = b[7:0]; bs[4] = b[15:8];
        txq.delete();
        send_bytes(bs, 5);
        w = 0;
        while (txq.size() < 3 && w < 100) begin
            @(negedge clock); #1; w++;
        end
        res = 16'hxxxx;
        flg = 8'hxx;
        if (txq.size() == 3) begin
            res = {txq[1], txq[0]};
            flg = txq[2];
        end
        w = 0;
        while (o_busy !== 1'b0 && w < 20) begin
            @(posedge clock); #1; w++;
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        i_rx_empty = 1'b1;
        i_tx_full = 1'b0;
        i_r_data = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({o_rd_uart, o_wr_uart, o_busy, o_timeout} !== 4'b0000) begin
            $display("FAIL reset_ctrl: got %b required 0000",
                     {o_rd_uart, o_wr_uart, o_busy, o_timeout});
        end else passed++;
        checks++;
        if (o_w_data !== 8'h00) begin
            $display("FAIL reset_wdata: got %h required 00", o_w_data);
        end else passed++;
        @(posedge clock); #1;
        i_reset = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (o_busy !== 1'b0) begin
            $display("FAIL reset_idle: busy %b required 0", o_busy);
        end else passed++;
    endtask

    task automatic test_add();
        logic [7:0] bs[5];
        bit busy_ok;
        int w, first_w, rd0;
        bs[0] = 8'h20; bs[1] = 8'h34; bs[2] = 8'h12;
        bs[3] = 8'hCD; bs[4] = 8'hAB;
        txq.delete();
        rd0 = rd_cnt;
        busy_ok = 1;
        i_rx_empty = 1'b0;
        i_r_data = bs[0];
        @(posedge clock); #1;
        for (int i = 1; i < 5; i++) begin
            i_r_data = bs[i];
            @(negedge clock);
            if (o_busy !== 1'b1) busy_ok = 0;
            @(posedge clock); #1;
        end
        i_rx_empty = 1'b1;
        w = 0;
        first_w = 0;
        while (txq.size() < 3 && w < 50) begin
            @(negedge clock);
            if (o_busy !== 1'b1) busy_ok = 0;
            #1; w++;
            if (first_w == 0 && txq.size() > 0) first_w = w;
        end
        checks++;
        if (txq.size() != 3) begin
            $display("FAIL add_count: got %0d bytes required 3", txq.size());
        end else passed++;
        if (txq.size() == 3) begin
            checks++;
            if ({txq[2], txq[1], txq[0]} !== 24'h00BE01) begin
                $display("FAIL add_bytes: got %h %h %h required 01 BE 00",
                         txq[0], txq[1], txq[2]);
            end else passed++;
        end
        checks++;
        if (first_w != 2) begin
            $display("FAIL add_latency: got %0d cycles required 2", first_w);
        end else passed++;
        checks++;
        if (!busy_ok) begin
            $display("FAIL add_busy: busy dropped, required 1 throughout");
        end else passed++;
        checks++;
        if (rd_cnt - rd0 != 5) begin
            $display("FAIL add_pops: got %0d required 5", rd_cnt - rd0);
        end else passed++;
        @(posedge clock); #1;
        @(negedge clock);
        checks++;
        if (o_busy !== 1'b0) begin
            $display("FAIL add_idle: busy %b required 0", o_busy);
        end else passed++;
        @(posedge clock); #1;
    endtask

    task automatic test_vectors(input string name, input logic [7:0] op[8],
                                input logic [15:0] av[8], input logic [15:0] bv[8],
                                input logic [15:0] rv[8], input logic [7:0] fv[8],
                                input int n);
        logic [15:0] res;
        logic [7:0] flg;
        for (int i = 0; i < n; i++) begin
            do_frame(op[i], av[i], bv[i], res, flg);
            checks++;
            if (res !== rv[i] || flg !== fv[i]) begin
                $display("FAIL %s[%0d]: got res %h flags %h required %h %h",
                         name, i, res, flg, rv[i], fv[i]);
            end else passed++;
        end
    endtask

    task automatic test_arith();
        logic [7:0] op[8];
        logic [15:0] av[8], bv[8], rv[8];
        logic [7:0] fv[8];
        op = '{8'h22, 8'h20, 8'h20, 8'h22, 8'h22, 8'h20, 8'h20, 8'h22};
        av = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h0001,
               16'h1234, 16'h8000, 16'h0000, 16'h7FFF};
        bv = '{16'h0001, 16'h0001, 16'h0001, 16'h0002,
               16'h1234, 16'h8000, 16'h0000, 16'hFFFF};
        rv = '{16'h7FFF, 16'h0000, 16'h8000, 16'hFFFF,
               16'h0000, 16'h0000, 16'h0000, 16'h8000};
        fv = '{8'h04, 8'h03, 8'h04, 8'h02, 8'h01, 8'h07, 8'h01, 8'h06};
        test_vectors("arith", op, av, bv, rv, fv, 8);
    endtask

    task automatic test_shift();
        logic [7:0] op[8];
        logic [15:0] av[8], bv[8], rv[8];
        logic [7:0] fv[8];
        op = '{8'h03, 8'h03, 8'h02, 8'h02, 8'h03, 8'h03, 8'h02, 8'h03};
        av = '{16'h8000, 16'h8000, 16'h8000, 16'h8000,
               16'h4000, 16'h8000, 16'h8000, 16'h1234};
        bv = '{16'h0004, 16'h0020, 16'h0020, 16'h0004,
               16'h000F, 16'h000F, 16'h0010, 16'h0010};
        rv = '{16'hF800, 16'hFFFF, 16'h0000, 16'h0800,
               16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
        fv = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 8'h01};
        test_vectors("shift", op, av, bv, rv, fv, 8);
    endtask

    task automatic test_logic();
        logic [7:0] op[8];
        logic [15:0] av[8], bv[8], rv[8];
        logic [7:0] fv[8];
        op = '{8'h24, 8'h25, 8'h26, 8'h26, 8'h27, 8'h27, 8'h24, 8'h25};
        av = '{16'hF0F0, 16'hF0F0, 16'hAAAA, 16'hAAAA,
               16'h0F0F, 16'h1234, 16'h00FF, 16'h0000};
        bv = '{16'h3C3C, 16'h0F0F, 16'hAAAA, 16'h5555,
               16'hF0F0, 16'h0000, 16'hFF00, 16'h0000};
        rv = '{16'h3030, 16'hFFFF, 16'h0000, 16'hFFFF,
               16'h0000, 16'hEDCB, 16'h0000, 16'h0000};
        fv = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 8'h01};
        test_vectors("logic", op, av, bv, rv, fv, 8);
    endtask

    task automatic test_invalid();
        logic [7:0] op[8];
        logic [15:0] av[8], bv[8], rv[8];
        logic [7:0] fv[8];
        op = '{8'h3F, 8'h00, 8'hE0, 8'hC3, 8'h21, 8'hA2, 8'h3F, 8'h20};
        av = '{16'h1111, 16'h5555, 16'h1234, 16'h8000,
               16'h0001, 16'h8000, 16'hFFFF, 16'h0001};
        bv = '{16'h2222, 16'h0001, 16'hABCD, 16'h0004,
               16'h0001, 16'h0001, 16'hFFFF, 16'h0001};
        rv = '{16'h0000, 16'h0000, 16'hBE01, 16'hF800,
               16'h0000, 16'h7FFF, 16'h0000, 16'h0002};
        fv = '{8'h09, 8'h09, 8'h00, 8'h00, 8'h09, 8'h04, 8'h09, 8'h00};
        test_vectors("invalid", op, av, bv, rv, fv, 8);
    endtask

    task automatic test_timeout();
        logic [7:0] bs[5];
        logic [15:0] res;
        logic [7:0] flg;
        int wr0, to0, first;
        bs[0] = 8'h20; bs[1] = 8'h55; bs[2] = 0; bs[3] = 0; bs[4] = 0;
        wr0 = wr_cnt;
        to0 = to_seen;
        first = -1;
        send_bytes(bs, 2);
        for (int e = 1; e <= 40; e++) begin
            @(posedge clock);
            @(negedge clock);
            if (o_timeout === 1'b1 && first < 0) first = e;
        end
        @(posedge clock); #1;
        checks++;
        if (first != TIMEOUT) begin
            $display("FAIL to_delay: got %0d edges required %0d", first, TIMEOUT);
        end else passed++;
        checks++;
        if (to_seen - to0 != 1) begin
            $display("FAIL to_pulses: got %0d required 1", to_seen - to0);
        end else passed++;
        checks++;
        if (wr_cnt != wr0 || o_busy !== 1'b0) begin
            $display("FAIL to_abort: pushes %0d busy %b required 0 0",
                     wr_cnt - wr0, o_busy);
        end else passed++;
        do_frame(8'h20, 16'h1234, 16'hABCD, res, flg);
        checks++;
        if (res !== 16'hBE01 || flg !== 8'h00) begin
            $display("FAIL to_recover: got %h %h required BE01 00", res, flg);
        end else passed++;
    endtask

    task automatic test_tx_full();
        logic [7:0] bs[5];
        bit stall_ok;
        int w, wr0;
        bs[0] = 8'h20; bs[1] = 8'h34; bs[2] = 8'h12;
        bs[3] = 8'hCD; bs[4] = 8'hAB;
        txq.delete();
        wr0 = wr_cnt;
        stall_ok = 1;
        i_tx_full = 1'b1;
        send_bytes(bs, 5);
        @(posedge clock); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (o_wr_uart !== 1'b0 || o_w_data !== 8'h01 || o_busy !== 1'b1) begin
                stall_ok = 0;
            end
            @(posedge clock); #1;
        end
        checks++;
        if (!stall_ok || txq.size() != 0) begin
            $display("FAIL stall_hold: pushes %0d data %h required 0 01",
                     txq.size(), o_w_data);
        end else passed++;
        i_tx_full = 1'b0;
        w = 0;
        while (txq.size() < 3 && w < 50) begin
            @(negedge clock); #1; w++;
        end
        repeat (10) @(posedge clock);
        #1;
        checks++;
        if (wr_cnt - wr0 != 3) begin
            $display("FAIL stall_pushes: got %0d required 3", wr_cnt - wr0);
        end else passed++;
        if (txq.size() == 3) begin
            checks++;
            if ({txq[2], txq[1], txq[0]} !== 24'h00BE01) begin
                $display("FAIL stall_bytes: got %h %h %h required 01 BE 00",
                         txq[0], txq[1], txq[2]);
            end else passed++;
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] bs[5];
        logic [15:0] res;
        logic [7:0] flg;
        int wr0;
        bs[0] = 8'h20; bs[1] = 8'h11; bs[2] = 8'h22; bs[3] = 8'h33; bs[4] = 0;
        wr0 = wr_cnt;
        send_bytes(bs, 4);
        checks++;
        if (o_busy !== 1'b1) begin
            $display("FAIL mid_busy: got %b required 1", o_busy);
        end else passed++;
        i_reset = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        checks++;
        if ({o_rd_uart, o_wr_uart, o_busy, o_timeout} !== 4'b0000 ||
            o_w_data !== 8'h00) begin
            $display("FAIL mid_reset: got %b %h required 0000 00",
                     {o_rd_uart, o_wr_uart, o_busy, o_timeout}, o_w_data);
        end else passed++;
        @(posedge clock); #1;
        i_reset = 1'b1;
        do_frame(8'h22, 16'h0005, 16'h0003, res, flg);
        checks++;
        if (res !== 16'h0002 || flg !== 8'h00) begin
            $display("FAIL mid_fresh: got %h %h required 0002 00", res, flg);
        end else passed++;
        checks++;
        if (wr_cnt - wr0 != 3) begin
            $display("FAIL mid_pushes: got %0d required 3", wr_cnt - wr0);
        end else passed++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_arith();
        test_shift();
        test_logic();
        test_invalid();
        test_timeout();
        test_tx_full();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
